// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency line-granular backing memory
// Accepts one line read or write in IDLE and completes it LATENCY cycles later.
module line_memory #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              count;
  logic [INDEX_BITS-1:0]   index;
  logic                    is_write;
  logic [127:0]            wdata;
  logic [127:0]            mem [LINES];
  logic                    accept;
  logic                    unused_addr;

  // Offset bits and bits above the index are deliberately ignored (aliasing).
  assign unused_addr = ^{pmem_address[15:INDEX_BITS+4], pmem_address[3:0]};

  assign accept = (state == IDLE) && (pmem_read || pmem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_next = WAIT;
      WAIT:    if (count == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp = (state == RESP);
    busy      = (state != IDLE);
  end

  // Request is captured once; later changes on the inputs are not observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 4'd0;
      index    <= '0;
      is_write <= 1'b0;
      wdata    <= '0;
    end else if (accept) begin
      count    <= COUNT_INIT;
      index    <= pmem_address[INDEX_BITS+3:4];
      is_write <= pmem_write;
      wdata    <= pmem_wdata;
    end else if (state == WAIT && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Read data is loaded on the edge entering RESP so it is valid for the whole strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_rdata <= '0;
    end else if (state == WAIT && count == 4'd0 && !is_write) begin
      pmem_rdata <= mem[index];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem[i] <= '0;
      end
    end else if (state == RESP && is_write) begin
      mem[index] <= wdata;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - self-checking bench for line_memory
// Scoreboard of expected pmem_rdata per transaction, popped on each pmem_resp.
module tb_line_memory;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;

  logic [15:0]  address2;
  logic         read2;
  logic         write2;
  logic [127:0] wdata2;
  logic [127:0] rdata2;
  logic         resp2;
  logic         busy2;

  int checks = 0;
  int failures = 0;

  logic [127:0] model [32];
  logic [127:0] rd_model;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  line_memory #(.LATENCY(4), .INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst), .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .busy(busy)
  );

  line_memory #(.LATENCY(2), .INDEX_BITS(5)) dut2 (
    .clk(clk), .rst(rst), .pmem_address(address2), .pmem_read(read2),
    .pmem_write(write2), .pmem_wdata(wdata2), .pmem_rdata(rdata2),
    .pmem_resp(resp2), .busy(busy2)
  );

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd_model = '0;
    exp_q.delete();
  endtask

  task automatic issue(input logic [15:0] a, input logic r, input logic w, input logic [127:0] d);
    pmem_address = a;
    pmem_read    = r;
    pmem_write   = w;
    pmem_wdata   = d;
    if (w) begin
      exp_q.push_back(rd_model);
      model[a[8:4]] = d;
    end else begin
      rd_model = model[a[8:4]];
      exp_q.push_back(rd_model);
    end
  endtask

  task automatic idle_inputs();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input int exp_busy, input string name);
    int n;
    int b;
    bit got;
    logic [127:0] exp;
    n = 0;
    b = 0;
    got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (busy) b++;
      if (pmem_resp) got = 1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no pmem_resp after %0d cycles, required latency %0d", name, n, exp_lat);
    end else begin
      checks++;
      if (n !== exp_lat) begin
        failures++;
        $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
      checks++;
      if (b !== exp_busy) begin
        failures++;
        $display("FAIL %s busy cycles: got %0d, required %0d", name, b, exp_busy);
      end
      exp = exp_q.pop_front();
      checks++;
      if (pmem_rdata !== exp) begin
        failures++;
        $display("FAIL %s rdata: got %h, required %h", name, pmem_rdata, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    pmem_address = '0;
    pmem_wdata = '0;
    read2 = 1'b0;
    write2 = 1'b0;
    address2 = '0;
    wdata2 = '0;
    clear_model();
    #1;
    checks++;
    if (pmem_resp !== 1'b0 || busy !== 1'b0 || pmem_rdata !== '0) begin
      failures++;
      $display("FAIL reset outputs: resp=%b busy=%b rdata=%h, required 0 0 0", pmem_resp, busy, pmem_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL post-reset idle: busy=%b resp=%b, required 0 0", busy, pmem_resp);
    end
  endtask

  task automatic test_read_basic();
    issue(16'h0040, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "read_0040");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    issue(16'h0120, 1'b0, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    wait_resp(4, 4, "write_0120");
    idle_inputs();
    @(negedge clk);
    issue(16'h012C, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "read_012C");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_alias();
    issue(16'h0010, 1'b0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    wait_resp(4, 4, "alias_write_a");
    idle_inputs();
    @(negedge clk);
    issue(16'h0210, 1'b0, 1'b1, 128'hBBBB_0000_CCCC_1111_DDDD_2222_EEEE_3333);
    wait_resp(4, 4, "alias_write_b");
    idle_inputs();
    @(negedge clk);
    issue(16'h0010, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "alias_read");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_read_held();
    issue(16'h0120, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "held_first");
    rd_model = model[5'h12];
    exp_q.push_back(rd_model);
    wait_resp(5, 4, "held_second");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_deassert();
    issue(16'h0070, 1'b0, 1'b1, 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0);
    @(negedge clk);
    pmem_address = 16'h0080;
    pmem_wdata   = '1;
    idle_inputs();
    wait_resp(3, 3, "deassert_write");
    @(negedge clk);
    issue(16'h0070, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "deassert_readback");
    idle_inputs();
    @(negedge clk);
    issue(16'h0080, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "deassert_other");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(16'h01F0, 1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    wait_resp(4, 4, "b2b_write");
    issue(16'h01F4, 1'b1, 1'b0, '0);
    wait_resp(5, 4, "b2b_read");
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_latency2();
    int n;
    logic [127:0] data;
    data = 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789;
    address2 = 16'h0050;
    read2 = 1'b1;
    write2 = 1'b1;
    wdata2 = data;
    n = 0;
    while (n < 10 && !resp2) begin
      @(negedge clk);
      n++;
    end
    read2 = 1'b0;
    write2 = 1'b0;
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL lat2_both latency: got %0d cycles, required 2", n);
    end
    checks++;
    if (rdata2 !== '0) begin
      failures++;
      $display("FAIL lat2_both rdata: got %h, required 0", rdata2);
    end
    @(negedge clk);
    address2 = 16'h0050;
    read2 = 1'b1;
    n = 0;
    while (n < 10 && !resp2) begin
      @(negedge clk);
      n++;
    end
    read2 = 1'b0;
    checks++;
    if (n !== 2 || rdata2 !== data) begin
      failures++;
      $display("FAIL lat2_read: got %0d cycles data %h, required 2 cycles data %h", n, rdata2, data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(16'h0300, 1'b0, 1'b1, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pmem_resp !== 1'b0 || pmem_rdata !== '0) begin
      failures++;
      $display("FAIL mid_reset outputs: busy=%b resp=%b rdata=%h, required 0 0 0", busy, pmem_resp, pmem_rdata);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pmem_resp) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_reset resp: got %0d pulses, required 0", seen);
    end
    issue(16'h0300, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "mid_reset_readback");
    idle_inputs();
    @(negedge clk);
    issue(16'h0120, 1'b1, 1'b0, '0);
    wait_resp(4, 4, "mid_reset_cleared");
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_alias();
    test_read_held();
    test_deassert();
    test_back_to_back();
    test_latency2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
